div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider in the EX stage. It consumes the `FUNCT_DIV`/`FUNCT_DIVU` operations decoded in ID and produces quotient (LO) and remainder (HI). It uses radix-2 restoring division with a fixed latency. While the divider is busy, the pipeline control stalls ID/EX until `done`.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width.

Ports:
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous abort, for an exception or pipeline flush.
- `start` input 1: request a division. Sampled only in IDLE.
- `is_signed` input 1: 1 for `FUNCT_DIV`, 0 for `FUNCT_DIVU`.
- `operand_a` input DATA_WIDTH: dividend (rs).
- `operand_b` input DATA_WIDTH: divisor (rt).
- `busy` output 1: operation in progress. The stall request.
- `done` output 1: one-cycle pulse; results valid.
- `quotient` output DATA_WIDTH: to LO.
- `remainder` output DATA_WIDTH: to HI.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, on `start && !flush`:
  - Latch sign_q = `is_signed` & (a[31]^b[31]) and sign_r = `is_signed` & a[31].
  - Latch |a| and |b|; magnitudes are taken only when `is_signed`.
  - Clear the 33-bit partial remainder and the 5-bit counter, then go to CALC.
- CALC, one iteration per cycle:
  - Shift {rem, dividend} left by 1.
  - Compute trial = rem − |b| in 33-bit arithmetic.
  - If trial is non-negative, rem = trial and the quotient bit is 1.
  - The counter increments; on count 31 go to FIX.
- FIX:
  - Negate the quotient if sign_q; negate the remainder if sign_r.
  - Load the `quotient`/`remainder` output registers, then go to DONE.
- DONE: `done`=1 for exactly this cycle, then return to IDLE unconditionally.
- `busy` = 1 in CALC and FIX; 0 in IDLE and DONE.
- Divide by zero (b==0): same latency, with forced results `quotient`=32'hFFFF_FFFF and `remainder`=`operand_a` as originally presented. Flag this at start.
- Signed overflow, 0x8000_0000 / −1: `quotient`=0x8000_0000, `remainder`=0. This falls out of the magnitude arithmetic naturally; no special case is needed.
- Remainder sign follows the dividend; quotient truncates toward zero (MIPS semantics).
- `start` in CALC/FIX/DONE is ignored, and operands are not re-sampled.
- `flush` in any state: next state IDLE, no `done` pulse. The output registers keep their previous values.
- `flush` together with `start` in IDLE: flush wins and nothing is started.
- `quotient`/`remainder` hold the last result until the next FIX.

## Timing
- Reset: state IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0, and the internal counter and registers are 0.
- `start` is sampled at edge 0.
- `busy` is high from cycle 1 through cycle 33.
- Edges 1–32 perform the 32 iterations.
- Edge 33 executes FIX, so `done`=1 and results are valid in cycle 34.
- Total latency: 34 cycles from the start cycle to `done`.
- A new `start` is accepted in the cycle after DONE, so back-to-back issue is 35 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-operation: immediately return to the reset values. A pending `done` is lost.

## Structure
- Add `define/div.v` with:
  - the state encodings `DIV_STATE_IDLE/CALC/FIX/DONE` (2 bits);
  - `DIV_CYCLES` = 32;
  - `DIV_CNT_BUS` = 4:0.
- Data widths come from the existing `DATA_BUS` in `bus.v`.
- The ID/EX decode of `FUNCT_DIV`/`FUNCT_DIVU` into `start`/`is_signed` lives in the EX wrapper, not in this block.
- Single module, no sub-modules; the 33-bit subtract is inline.

## Test plan
- Unsigned 100 / 7: `start` at cycle 0 gives `done` in cycle 34 with `quotient`=14, `remainder`=2. `busy` is high in cycles 1–33 only.
- Signed −7 / 2: `quotient`=32'hFFFF_FFFD, `remainder`=32'hFFFF_FFFF. The same operands with `is_signed`=0 give `quotient`=32'h7FFF_FFFC, `remainder`=1.
- Signed 0x8000_0000 / 0xFFFF_FFFF: `quotient`=0x8000_0000, `remainder`=0.
- 5 / 0, both modes: `quotient`=32'hFFFF_FFFF, `remainder`=5, `done` in cycle 34.
- `flush` in cycle 10:
  - `busy`=0 from cycle 11 and no `done`, with the outputs keeping the prior result.
  - `start` in cycle 11 is accepted and completes in cycle 45.
  - `start` plus `flush` together in IDLE is ignored.
- `rst` pulsed mid-CALC: all outputs read 0 immediately. `start` held high throughout the operation is not re-accepted until after the DONE cycle.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

  localparam int unsigned DivDataWidth = 32;
  localparam int unsigned DivCycles    = DivDataWidth;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider: one quotient bit per cycle, sign fix-up, one-cycle done pulse.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DivDataWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  div_state_e            r_state, w_state_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic [DATA_WIDTH-1:0] r_rem, w_rem_d;
  logic [DATA_WIDTH-1:0] r_dvd, w_dvd_d;
  logic [DATA_WIDTH-1:0] r_dvs, w_dvs_d;
  logic [DATA_WIDTH-1:0] r_a_orig, w_a_orig_d;
  logic                  r_sign_q, w_sign_q_d;
  logic                  r_sign_r, w_sign_r_d;
  logic                  r_div0, w_div0_d;
  logic [DATA_WIDTH-1:0] r_quot, w_quot_d;
  logic [DATA_WIDTH-1:0] r_remo, w_remo_d;
  logic                  r_busy, w_busy_d;
  logic                  r_done, w_done_d;
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_trial;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_rem_d    = r_rem;
    w_dvd_d    = r_dvd;
    w_dvs_d    = r_dvs;
    w_a_orig_d = r_a_orig;
    w_sign_q_d = r_sign_q;
    w_sign_r_d = r_sign_r;
    w_div0_d   = r_div0;
    w_quot_d   = r_quot;
    w_remo_d   = r_remo;
    // Stored remainder is always below the divisor, so W bits suffice; the trial needs W+1.
    w_shift    = {r_rem, r_dvd[DATA_WIDTH-1]};
    w_trial    = w_shift - {1'b0, r_dvs};

    unique case (r_state)
      StIdle: begin
        if (start && !flush) begin
          w_sign_q_d = is_signed & (operand_a[DATA_WIDTH-1] ^ operand_b[DATA_WIDTH-1]);
          w_sign_r_d = is_signed & operand_a[DATA_WIDTH-1];
          w_dvd_d    = (is_signed && operand_a[DATA_WIDTH-1]) ? -operand_a : operand_a;
          w_dvs_d    = (is_signed && operand_b[DATA_WIDTH-1]) ? -operand_b : operand_b;
          w_a_orig_d = operand_a;
          w_div0_d   = (operand_b == '0);
          w_rem_d    = '0;
          w_cnt_d    = '0;
          w_state_d  = StCalc;
        end
      end
      StCalc: begin
        if (!w_trial[DATA_WIDTH]) begin
          w_rem_d = w_trial[DATA_WIDTH-1:0];
          w_dvd_d = {r_dvd[DATA_WIDTH-2:0], 1'b1};
        end else begin
          w_rem_d = w_shift[DATA_WIDTH-1:0];
          w_dvd_d = {r_dvd[DATA_WIDTH-2:0], 1'b0};
        end
        w_cnt_d = r_cnt + 1'b1;
        if (r_cnt == LastCnt) begin
          w_state_d = StFix;
        end
      end
      StFix: begin
        if (r_div0) begin
          w_quot_d = '1;
          w_remo_d = r_a_orig;
        end else begin
          w_quot_d = r_sign_q ? -r_dvd : r_dvd;
          w_remo_d = r_sign_r ? -r_rem : r_rem;
        end
        w_state_d = StDone;
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // Abort keeps the previously published result intact.
    if (flush) begin
      w_state_d = StIdle;
      w_quot_d  = r_quot;
      w_remo_d  = r_remo;
    end

    w_busy_d = (w_state_d == StCalc) || (w_state_d == StFix);
    w_done_d = (w_state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_a_orig <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
      r_quot   <= '0;
      r_remo   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_rem    <= w_rem_d;
      r_dvd    <= w_dvd_d;
      r_dvs    <= w_dvs_d;
      r_a_orig <= w_a_orig_d;
      r_sign_q <= w_sign_q_d;
      r_sign_r <= w_sign_r_d;
      r_div0   <= w_div0_d;
      r_quot   <= w_quot_d;
      r_remo   <= w_remo_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remo;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table through a scoreboard plus flush/reset/hold sequences.
module tb_div_unit;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start;
  logic        is_signed;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];
  vec_t vecs[12];

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .is_signed (is_signed),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("sb_quotient", quotient, e[63:32]);
        chk("sb_remainder", remainder, e[31:0]);
      end
    end
  end

  // Called just after the start edge s; watches cycles s+1 .. s+35.
  task automatic await_done(input int s, input bit keep, input string name);
    int first = -1;
    int ndone = 0;
    int bad   = -1;
    for (int c = s + 1; c <= s + 35; c++) begin
      @(negedge clk);
      if (!keep) start = 1'b0;
      if ((busy !== ((c <= s + 33) ? 1'b1 : 1'b0)) && bad < 0) bad = c - s;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c - s;
      end
    end
    chk_int({name, " latency"}, first, 34);
    chk_int({name, " done_pulses"}, ndone, 1);
    chk_int({name, " busy_first_bad_cycle"}, bad, -1);
  endtask

  task automatic run_op(input vec_t v, input string name);
    @(negedge clk);
    operand_a = v.a;
    operand_b = v.b;
    is_signed = v.s;
    start     = 1'b1;
    sb_q.push_back({v.q, v.r});
    @(posedge clk);
    await_done(0, 1'b0, name);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; start = 1'b0; is_signed = 1'b0;
    operand_a = '0; operand_b = '0;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1};
    vecs[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    vecs[4]  = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
    vecs[5]  = '{32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5};
    vecs[6]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
    vecs[7]  = '{32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b1, 32'd2,          32'hFFFF_FFFE};
    vecs[8]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
    vecs[9]  = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3};
    vecs[10] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[11] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};

    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Flush in cycle 10 aborts; restart in cycle 11 completes in cycle 45.
    run_op(vecs[0], "pre_flush");
    @(negedge clk);
    operand_a = 32'd1000; operand_b = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy_c11", {31'd0, busy}, 32'd0);
    chk("flush hold_quotient", quotient, 32'd14);
    chk("flush hold_remainder", remainder, 32'd2);
    start = 1'b1;
    sb_q.push_back({32'd333, 32'd1});
    @(posedge clk);
    await_done(11, 1'b0, "post_flush");

    // start together with flush in IDLE must be ignored.
    @(negedge clk);
    operand_a = 32'd9; operand_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start_flush busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("start_flush busy_later", {31'd0, busy}, 32'd0);
    chk("start_flush quotient", quotient, 32'd333);

    // Reset mid-CALC clears everything at once.
    @(negedge clk);
    operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    start = 1'b0;
    chk("pre_rst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst quotient", quotient, 32'd0);
    chk("rst remainder", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst busy", {31'd0, busy}, 32'd0);

    // start held high: operands changed mid-op are ignored, re-accepted after DONE.
    @(negedge clk);
    operand_a = 32'd50; operand_b = 32'd5; is_signed = 1'b0; start = 1'b1;
    sb_q.push_back({32'd10, 32'd0});
    @(posedge clk);
    #1;
    operand_a = 32'd77; operand_b = 32'd4;
    await_done(0, 1'b1, "hold_first");
    sb_q.push_back({32'd19, 32'd1});
    @(posedge clk);
    await_done(35, 1'b0, "hold_second");

    repeat (3) @(negedge clk);
    chk_int("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
